// File: rtl/idex_pipeline_reg.sv
// ID/EX pipeline register with stall hold, flush bubble and valid tag.
// Optional performance counters enabled by defining IDEX_PERF_CNT_EN.
module idex_pipeline_reg #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [4:0]        id_EX,
    input  logic [2:0]        id_M,
    input  logic [2:0]        id_WB,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              idex_stall,
    input  logic              idex_flush,
`ifdef IDEX_PERF_CNT_EN
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  perf_bubble_cnt,
    output logic [CNT_W-1:0]  perf_stall_cnt,
`endif
    output logic [4:0]        idex_EX,
    output logic [2:0]        idex_M,
    output logic [2:0]        idex_WB,
    output logic              idex_valid,
    output logic [XLEN-1:0]   idex_pc,
    output logic [XLEN-1:0]   idex_rs1_data,
    output logic [XLEN-1:0]   idex_rs2_data,
    output logic [XLEN-1:0]   idex_imm,
    output logic [REG_AW-1:0] idex_rs1,
    output logic [REG_AW-1:0] idex_rs2,
    output logic [REG_AW-1:0] idex_rd,
    output logic              idex_held
);

    // Flush only clears control and valid; data fields are don't-care once valid is low.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            idex_EX       <= '0;
            idex_M        <= '0;
            idex_WB       <= '0;
            idex_valid    <= 1'b0;
            idex_pc       <= '0;
            idex_rs1_data <= '0;
            idex_rs2_data <= '0;
            idex_imm      <= '0;
            idex_rs1      <= '0;
            idex_rs2      <= '0;
            idex_rd       <= '0;
            idex_held     <= 1'b0;
        end else if (idex_flush) begin
            idex_EX    <= '0;
            idex_M     <= '0;
            idex_WB    <= '0;
            idex_valid <= 1'b0;
            idex_held  <= 1'b0;
        end else if (idex_stall) begin
            idex_held <= 1'b1;
        end else begin
            idex_EX       <= id_EX;
            idex_M        <= id_M;
            idex_WB       <= id_WB;
            idex_valid    <= id_valid;
            idex_pc       <= id_pc;
            idex_rs1_data <= id_rs1_data;
            idex_rs2_data <= id_rs2_data;
            idex_imm      <= id_imm;
            idex_rs1      <= id_rs1;
            idex_rs2      <= id_rs2;
            idex_rd       <= id_rd;
            idex_held     <= 1'b0;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    // Bubble and stall-hold event counters; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rstn || perf_clr) begin
            perf_bubble_cnt <= '0;
            perf_stall_cnt  <= '0;
        end else if (idex_flush) begin
            perf_bubble_cnt <= perf_bubble_cnt + CNT_W'(1);
        end else if (idex_stall) begin
            perf_stall_cnt  <= perf_stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_idex_pipeline_reg.sv
// Scoreboard bench for idex_pipeline_reg: expected state queued per edge, compared after it.
module tb_idex_pipeline_reg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic [4:0]        id_EX;
    logic [2:0]        id_M, id_WB;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              idex_stall, idex_flush;
    logic [4:0]        idex_EX;
    logic [2:0]        idex_M, idex_WB;
    logic              idex_valid;
    logic [XLEN-1:0]   idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
    logic [REG_AW-1:0] idex_rs1, idex_rs2, idex_rd;
    logic              idex_held;
`ifdef IDEX_PERF_CNT_EN
    logic              perf_clr;
    logic [CNT_W-1:0]  perf_bubble_cnt, perf_stall_cnt;
    logic [CNT_W-1:0]  m_bub, m_stl;
`endif

    typedef struct packed {
        logic [4:0]        ex;
        logic [2:0]        m;
        logic [2:0]        wb;
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1d;
        logic [XLEN-1:0]   rs2d;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              held;
    } exp_t;

    exp_t model;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    idex_pipeline_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .id_EX(id_EX), .id_M(id_M), .id_WB(id_WB), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .idex_stall(idex_stall), .idex_flush(idex_flush),
`ifdef IDEX_PERF_CNT_EN
        .perf_clr(perf_clr), .perf_bubble_cnt(perf_bubble_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .idex_EX(idex_EX), .idex_M(idex_M), .idex_WB(idex_WB), .idex_valid(idex_valid),
        .idex_pc(idex_pc), .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data),
        .idex_imm(idex_imm), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_held(idex_held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_random();
        id_EX       = 5'($urandom);
        id_M        = 3'($urandom);
        id_WB       = 3'($urandom);
        id_valid    = 1'($urandom);
        id_pc       = XLEN'($urandom);
        id_rs1_data = XLEN'($urandom);
        id_rs2_data = XLEN'($urandom);
        id_imm      = XLEN'($urandom);
        id_rs1      = REG_AW'($urandom);
        id_rs2      = REG_AW'($urandom);
        id_rd       = REG_AW'($urandom);
    endtask

    // Advance one edge: predict from current inputs, queue, then compare after the edge.
    task automatic step();
        exp_t e;
        e = model;
        if (!rstn) begin
            e = '0;
        end else if (idex_flush) begin
            e.ex = '0; e.m = '0; e.wb = '0; e.valid = 1'b0; e.held = 1'b0;
        end else if (idex_stall) begin
            e.held = 1'b1;
        end else begin
            e.ex = id_EX; e.m = id_M; e.wb = id_WB; e.valid = id_valid;
            e.pc = id_pc; e.rs1d = id_rs1_data; e.rs2d = id_rs2_data; e.imm = id_imm;
            e.rs1 = id_rs1; e.rs2 = id_rs2; e.rd = id_rd; e.held = 1'b0;
        end
`ifdef IDEX_PERF_CNT_EN
        if (!rstn || perf_clr) begin
            m_bub = '0; m_stl = '0;
        end else if (idex_flush) begin
            m_bub = m_bub + CNT_W'(1);
        end else if (idex_stall) begin
            m_stl = m_stl + CNT_W'(1);
        end
`endif
        model = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("ex",    64'(idex_EX),       64'(e.ex));
        check("m",     64'(idex_M),        64'(e.m));
        check("wb",    64'(idex_WB),       64'(e.wb));
        check("valid", 64'(idex_valid),    64'(e.valid));
        check("pc",    64'(idex_pc),       64'(e.pc));
        check("rs1d",  64'(idex_rs1_data), 64'(e.rs1d));
        check("rs2d",  64'(idex_rs2_data), 64'(e.rs2d));
        check("imm",   64'(idex_imm),      64'(e.imm));
        check("rs1",   64'(idex_rs1),      64'(e.rs1));
        check("rs2",   64'(idex_rs2),      64'(e.rs2));
        check("rd",    64'(idex_rd),       64'(e.rd));
        check("held",  64'(idex_held),     64'(e.held));
`ifdef IDEX_PERF_CNT_EN
        check("bub_cnt", 64'(perf_bubble_cnt), 64'(m_bub));
        check("stl_cnt", 64'(perf_stall_cnt),  64'(m_stl));
`endif
    endtask

    initial begin
        model = '0;
        rstn = 1'b0; idex_stall = 1'b0; idex_flush = 1'b0;
`ifdef IDEX_PERF_CNT_EN
        perf_clr = 1'b0; m_bub = '0; m_stl = '0;
`endif
        drive_random();
        id_pc = 32'hDEAD_BEEF; id_EX = 5'h1F; id_valid = 1'b1;
        #2;

        // Reset with nonzero inputs
        step(); step();
        check("rst_pc",    64'(idex_pc),    64'h0);
        check("rst_ex",    64'(idex_EX),    64'h0);
        check("rst_valid", 64'(idex_valid), 64'h0);

        // First load after release
        rstn = 1'b1;
        id_EX = 5'h1A; id_M = 3'h5; id_WB = 3'h3; id_pc = 32'h100; id_valid = 1'b1;
        step();
        check("load_ex", 64'(idex_EX), 64'h1A);
        check("load_m",  64'(idex_M),  64'h5);
        check("load_wb", 64'(idex_WB), 64'h3);
        check("load_pc", 64'(idex_pc), 64'h100);

        // Three-edge stall while inputs change
        idex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            step();
        end
        check("stall_pc",   64'(idex_pc),   64'h100);
        check("stall_ex",   64'(idex_EX),   64'h1A);
        check("stall_held", 64'(idex_held), 64'h1);

        // Flush overrides stall; data fields keep their values
        idex_flush = 1'b1;
        step();
        check("flush_ex",    64'(idex_EX),    64'h0);
        check("flush_valid", 64'(idex_valid), 64'h0);
        check("flush_pc",    64'(idex_pc),    64'h100);
        check("flush_held",  64'(idex_held),  64'h0);

        // Release: new inputs load
        idex_flush = 1'b0; idex_stall = 1'b0;
        drive_random();
        id_pc = 32'h204;
        step();
        check("rel_pc",   64'(idex_pc),   64'h204);
        check("rel_held", 64'(idex_held), 64'h0);

        // Load with id_valid low keeps control verbatim
        id_valid = 1'b0; id_EX = 5'h0B;
        step();
        check("inv_ex",    64'(idex_EX),    64'h0B);
        check("inv_valid", 64'(idex_valid), 64'h0);

        // Reset mid-stall
        idex_stall = 1'b1; step();
        rstn = 1'b0; step();
        check("mid_rst_pc",   64'(idex_pc),   64'h0);
        check("mid_rst_held", 64'(idex_held), 64'h0);
        rstn = 1'b1; idex_stall = 1'b0;

        // Random mix of load/stall/flush and occasional reset
        for (int i = 0; i < 80; i++) begin
            drive_random();
            idex_stall = ($urandom_range(0, 2) == 0);
            idex_flush = ($urandom_range(0, 5) == 0);
            rstn       = ($urandom_range(0, 19) != 0);
            step();
        end
        rstn = 1'b1; idex_stall = 1'b0; idex_flush = 1'b0;

`ifdef IDEX_PERF_CNT_EN
        // Bubble counter wraps at 2^CNT_W
        perf_clr = 1'b1; step();
        perf_clr = 1'b0; idex_flush = 1'b1;
        for (int i = 0; i < 17; i++) step();
        check("bub_wrap", 64'(perf_bubble_cnt), 64'h1);
        idex_flush = 1'b0;
        // Clear dominates stall increments
        perf_clr = 1'b1; idex_stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("stl_clr", 64'(perf_stall_cnt), 64'h0);
        perf_clr = 1'b0;
        for (int i = 0; i < 2; i++) step();
        check("stl_cnt2", 64'(perf_stall_cnt), 64'h2);
        idex_stall = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
